// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder reused once per cycle by the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per cycle.
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;

  logic [IW-1:0]    bitIdx;
  logic             lastBit;
  logic             faSum, faCarry;

  // The counter reaches WIDTH only after the final bit, so the truncated index stays in range.
  assign bitIdx  = cnt_q[IW-1:0];
  assign lastBit = (cnt_q == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a  (a_q[bitIdx]),
    .b  (b_q[bitIdx]),
    .ci (carry_q),
    .s  (faSum),
    .co (faCarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operands are only loaded in IDLE, so starts seen in RUN or DONE cannot disturb them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[bitIdx] <= faSum;
          carry_q       <= faCarry;
          cnt_q         <= cnt_q + CW'(1);
          if (lastBit) cout_q <= faCarry;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against a plain-arithmetic model.
module tb_serial_add_ctrl;

  typedef struct {
    int     expSum;
    int     expCout;
    longint acceptCycle;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  longint cycle;
  int     checks;
  int     errors;
  exp_t   q8[$];
  exp_t   q1[$];
  int     lastSum8;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor for the 8-bit instance: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy8 || done8) checkOutput("w8_busy_done_exclusive", longint'(busy8 && done8), 0);
      if (done8) begin
        if (q8.size() == 0) begin
          checkOutput("w8_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          checkOutput("w8_sum", sum8, e.expSum);
          checkOutput("w8_cout", cout8, e.expCout);
          checkOutput("w8_latency", cycle, e.acceptCycle + 8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1 || done1) checkOutput("w1_busy_done_exclusive", longint'(busy1 && done1), 0);
      if (done1) begin
        if (q1.size() == 0) begin
          checkOutput("w1_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          checkOutput("w1_sum", sum1, e.expSum);
          checkOutput("w1_cout", cout1, e.expCout);
          checkOutput("w1_latency", cycle, e.acceptCycle + 1);
        end
      end
    end
  end

  task automatic waitDone8();
    int n;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) checkOutput("w8_done_timeout", 0, 1);
  endtask

  // Caller must be at a negedge with the DUT in IDLE; returns at the negedge of the done cycle.
  task automatic applyStimulus8(input int x, input int y, input int c);
    int total;
    total  = x + y + c;
    a8     = 8'(x);
    b8     = 8'(y);
    cin8   = c[0];
    start8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{total % 256, total / 256, cycle});
    lastSum8 = total % 256;
    @(negedge clk);
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    waitDone8();
  endtask

  task automatic applyStimulus1(input int x, input int y, input int c);
    int total;
    int n;
    total  = x + y + c;
    a1     = 1'(x);
    b1     = 1'(y);
    cin1   = c[0];
    start1 = 1'b1;
    @(posedge clk);
    #1;
    q1.push_back('{total % 2, total / 2, cycle});
    @(negedge clk);
    start1 = 1'b0;
    a1     = ~a1;
    b1     = ~b1;
    cin1   = ~cin1;
    n = 0;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done1) checkOutput("w1_done_timeout", 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cycle  = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    lastSum8 = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_done", done8, 0);
    checkOutput("reset_sum", sum8, 0);
    checkOutput("reset_cout", cout8, 0);

    // First start offered on the very first edge after reset release.
    rst_n = 1'b1;
    applyStimulus8(8'h5A, 8'h3C, 0);
    @(negedge clk);
    applyStimulus8(8'hFF, 8'h01, 0);
    @(negedge clk);
    applyStimulus8(8'hFF, 8'hFF, 1);

    repeat (3) @(negedge clk);
    checkOutput("sum_hold_idle", sum8, lastSum8);
    checkOutput("cout_hold_idle", cout8, 1);

    // Starts during RUN cycles 3 and 8 must be ignored.
    a8 = 8'h21; b8 = 8'h42; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{(8'h21 + 8'h42 + 1) % 256, 0, cycle});
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3 || i == 8) begin
        start8 = 1'b1; a8 = 8'hF0 + 8'(i); b8 = 8'hEE; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("ignored_start_done", done8, 1);
    repeat (4) @(negedge clk);
    checkOutput("ignored_start_idle", longint'(busy8 || done8), 0);

    // Reset asserted in RUN cycle 4 aborts with no done pulse.
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) @(negedge clk);
    start8 = 1'b0;
    rst_n  = 1'b0;
    q8.delete();
    #1;
    checkOutput("abort_busy", busy8, 0);
    checkOutput("abort_done", done8, 0);
    checkOutput("abort_sum", sum8, 0);
    checkOutput("abort_cout", cout8, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus8(8'h01, 8'h01, 0);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      applyStimulus1(v & 1, (v >> 1) & 1, (v >> 2) & 1);
    end

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      applyStimulus8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)));
    end

    repeat (12) @(negedge clk);
    checkOutput("w8_queue_drained", q8.size(), 0);
    checkOutput("w1_queue_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepted start.
REQ-007 SHALL have port cin  input  1  carry-in; captured on the accepted start.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (RUN state).
REQ-009 SHALL have port done  output  1  single-cycle pulse; sum and cout are valid.
REQ-010 SHALL have port sum  output  WIDTH  result bits, LSB computed first.
REQ-011 SHALL have port cout  output  1  final carry-out.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), using one 1-bit full-adder cell reused once per cycle.
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 IDLE: start=1 -> capture a, b and cin into the operand and carry registers; clear the bit counter; go to RUN. start=0 -> stay in IDLE.
REQ-015 RUN: per cycle, feed the cell with a[cnt], b[cnt] and the carry register; write the cell sum to sum[cnt]; load the carry register from the cell carry; increment cnt.
REQ-016 RUN -> DONE on the edge that processes bit WIDTH-1; cout then equals the final carry.
REQ-017 DONE: done=1 for exactly one cycle; unconditional return to IDLE on the next edge.
REQ-018 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH (WIDTH+1 cycles from start to done).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done never both 1.
REQ-020 start while in RUN or DONE SHALL be ignored; no queuing; operands SHALL be unaffected.
REQ-021 a, b and cin changing after capture SHALL NOT affect the result in progress.
REQ-022 sum and cout SHALL hold their last result through IDLE until the next accepted start overwrites them.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never index beyond WIDTH-1.
REQ-024 WIDTH=1: the FSM passes through RUN for one cycle; the result equals the full-adder truth table.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state=IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, operand registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block accepts a new start normally.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 The FSM state encoding (IDLE=0, RUN=1, DONE=2, 2-bit typedef) SHALL live in the shared package serial_add_pkg.
REQ-029 The 1-bit adder SHALL be a separate combinational sub-module, fa_cell (s, co, a, b, ci), instantiated once.
REQ-030 No other sub-modules; the counter, operand shift/index logic and FSM SHALL reside in serial_add_ctrl.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x3C, cin=0 -> done 9 cycles after start; sum=0x96; cout=0.
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 WIDTH=8: start pulsed again at cycles 3 and 8 of RUN with different operands -> first result is unchanged; exactly one done pulse.
REQ-034 WIDTH=8: rst_n low at the 4th RUN cycle -> busy, done, sum and cout are 0 immediately; no done pulse; a fresh 0x01+0x01 then yields 0x02.
REQ-035 WIDTH=1: all 8 combinations of a, b and cin -> {cout,sum} matches the full-adder truth table, done 2 cycles after each start.
REQ-036 WIDTH=8: 1000 random operand sets, back-to-back starts issued in IDLE -> every result matches a+b+cin; busy and done are never both 1.
